// File: rtl/wb_regbank_if.sv
// Wishbone B4 slave bus bundle for wb_regbank (data, address, cycle-type and handshake).
interface wb_regbank_if;
  logic [31:0] wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel_i;
  logic [2:0]  wb_cti_i;
  logic        wb_we_i;
  logic        wb_cyc_i;
  logic        wb_stb_i;
  logic        wb_ack_o;

  modport master (
    output wb_adr_i, wb_dat_i, wb_sel_i, wb_cti_i, wb_we_i, wb_cyc_i, wb_stb_i,
    input  wb_dat_o, wb_ack_o
  );

  modport slave (
    input  wb_adr_i, wb_dat_i, wb_sel_i, wb_cti_i, wb_we_i, wb_cyc_i, wb_stb_i,
    output wb_dat_o, wb_ack_o
  );
endinterface

// File: rtl/wb_regbank.sv
// 16-word Wishbone register bank: word 0 is a read-only ID, word 1 drives ctrl_o.
// Define WB_REGBANK_BURST_EN to enable incrementing-burst (cti=010) support.
module wb_regbank #(
  parameter logic [31:0] REG_ID   = 32'h5142_0001,
  parameter logic [31:0] CTRL_RST = 32'h0000_0000
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  wb_regbank_if.slave wb,
  output logic [31:0] ctrl_o
);

`ifdef WB_REGBANK_BURST_EN
  typedef enum logic [1:0] {StIdle, StAck, StBurst} state_e;
`else
  typedef enum logic [1:0] {StIdle, StAck} state_e;
`endif

  state_e      state_q, state_d;
  logic [3:0]  p_q, p_d;
  logic        ack_q, ack_d;
  logic [31:0] dat_q, dat_d;
  logic [31:0] regs_q [16];
  logic [31:0] regs_d [16];

  logic        access;
  logic [3:0]  acc_idx;
  logic        cyc_stb;

  assign cyc_stb = wb.wb_cyc_i & wb.wb_stb_i;

  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    ack_d   = 1'b0;
    dat_d   = dat_q;
    access  = 1'b0;
    acc_idx = p_q;
    case (state_q)
      StIdle: begin
        if (cyc_stb) begin
          access  = 1'b1;
          acc_idx = wb.wb_adr_i[5:2];
          p_d     = wb.wb_adr_i[5:2];
          state_d = StAck;
`ifdef WB_REGBANK_BURST_EN
          if (wb.wb_cti_i == 3'b010) state_d = StBurst;
`endif
        end
      end
      StAck: state_d = StIdle;
`ifdef WB_REGBANK_BURST_EN
      StBurst: begin
        // Burst beats address from the internal pointer, never from wb_adr_i.
        if (!wb.wb_cyc_i) begin
          state_d = StIdle;
        end else if (wb.wb_stb_i) begin
          access  = 1'b1;
          acc_idx = p_q + 4'd1;
          p_d     = acc_idx;
          if (wb.wb_cti_i == 3'b111) state_d = StAck;
        end
      end
`endif
      default: state_d = StIdle;
    endcase
    if (access) begin
      ack_d = 1'b1;
      dat_d = (acc_idx == 4'd0) ? REG_ID : regs_q[acc_idx];
    end
  end

  always_comb begin
    regs_d = regs_q;
    if (access && wb.wb_we_i && (acc_idx != 4'd0)) begin
      for (int b = 0; b < 4; b++) begin
        if (wb.wb_sel_i[b]) regs_d[acc_idx][8*b +: 8] = wb.wb_dat_i[8*b +: 8];
      end
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q <= StIdle;
      p_q     <= 4'd0;
      ack_q   <= 1'b0;
      dat_q   <= 32'd0;
      for (int i = 0; i < 16; i++) begin
        regs_q[i] <= (i == 1) ? CTRL_RST : 32'd0;
      end
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      ack_q   <= ack_d;
      dat_q   <= dat_d;
      regs_q  <= regs_d;
    end
  end

  assign wb.wb_ack_o = ack_q;
  assign wb.wb_dat_o = dat_q;
  assign ctrl_o      = regs_q[1];

`ifdef WB_REGBANK_BURST_EN
  logic unused_in;
  assign unused_in = ^{wb.wb_adr_i[31:6], wb.wb_adr_i[1:0]};
`else
  logic unused_in;
  assign unused_in = ^{wb.wb_adr_i[31:6], wb.wb_adr_i[1:0], wb.wb_cti_i};
`endif

endmodule

// File: tb/tb_wb_regbank.sv
// Self-checking bench for wb_regbank: classic vector table plus burst/abort/reset sequences.
module tb_wb_regbank;
  localparam logic [31:0] RegId   = 32'h5142_0001;
  localparam logic [31:0] CtrlRst = 32'hA5A5_0F0F;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic [31:0] ctrl_o;

  wb_regbank_if bus ();

  wb_regbank #(.REG_ID(RegId), .CTRL_RST(CtrlRst)) dut (
    .sys_clk(sys_clk),
    .sys_rst(sys_rst),
    .wb     (bus),
    .ctrl_o (ctrl_o)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    bit          we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic [2:0]  cti;
    logic [31:0] exp;
  } vec_t;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_q [$];
  logic [31:0] mdl [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mdl_rd(input logic [3:0] idx);
    return (idx == 4'd0) ? RegId : mdl[idx];
  endfunction

  task automatic mdl_wr(input logic [3:0] idx, input logic [31:0] d, input logic [3:0] sel);
    if (idx != 4'd0)
      for (int b = 0; b < 4; b++) if (sel[b]) mdl[idx][8*b +: 8] = d[8*b +: 8];
  endtask

  task automatic mdl_reset();
    for (int i = 0; i < 16; i++) mdl[i] = 32'd0;
    mdl[1] = CtrlRst;
    exp_q.delete();
  endtask

  // Every ack pops one expected read value; an ack with nothing pending is an error.
  always @(negedge sys_clk) begin
    if (!sys_rst && bus.wb_ack_o) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_ack: got ack=1, expected ack=0 at %0t", $time);
      end else begin
        check("ack_data", bus.wb_dat_o, exp_q.pop_front());
      end
    end
  end

  task automatic idle_bus();
    bus.wb_cyc_i = 1'b0;
    bus.wb_stb_i = 1'b0;
    bus.wb_we_i  = 1'b0;
    bus.wb_cti_i = 3'b000;
    bus.wb_sel_i = 4'h0;
    bus.wb_adr_i = 32'd0;
    bus.wb_dat_i = 32'd0;
  endtask

  task automatic classic(input vec_t v);
    @(negedge sys_clk);
    bus.wb_cyc_i = 1'b1;
    bus.wb_stb_i = 1'b1;
    bus.wb_we_i  = v.we;
    bus.wb_adr_i = v.adr;
    bus.wb_dat_i = v.dat;
    bus.wb_sel_i = v.sel;
    bus.wb_cti_i = v.cti;
    exp_q.push_back(v.exp);
    if (v.we) mdl_wr(v.adr[5:2], v.dat, v.sel);
    @(negedge sys_clk);
    idle_bus();
    @(negedge sys_clk);
    check("classic_ack_count", 32'(exp_q.size()), 32'd0);
    check("dat_hold", bus.wb_dat_o, v.exp);
  endtask

`ifdef WB_REGBANK_BURST_EN
  // Later beats carry a decoy address so a DUT that decodes wb_adr_i mid-burst is caught.
  task automatic burst(input bit we, input logic [31:0] adr, input int n,
                       input logic [31:0] base, input int gap_after, input bit abort);
    logic [3:0] idx;
    for (int k = 0; k < n; k++) begin
      @(negedge sys_clk);
      if (k == gap_after) begin
        bus.wb_stb_i = 1'b0;
        repeat (2) @(negedge sys_clk);
      end
      idx = adr[5:2] + 4'(k);
      bus.wb_cyc_i = 1'b1;
      bus.wb_stb_i = 1'b1;
      bus.wb_we_i  = we;
      bus.wb_adr_i = (k == 0) ? adr : 32'h0000_0024;
      bus.wb_dat_i = base + 32'(k);
      bus.wb_sel_i = 4'hF;
      bus.wb_cti_i = (k == n - 1 && !abort) ? 3'b111 : 3'b010;
      exp_q.push_back(mdl_rd(idx));
      if (we) mdl_wr(idx, base + 32'(k), 4'hF);
    end
    @(negedge sys_clk);
    if (abort) begin
      bus.wb_cyc_i = 1'b0;
      bus.wb_stb_i = 1'b1;
      bus.wb_we_i  = 1'b1;
      bus.wb_dat_i = 32'hBAD0_BAD0;
      @(negedge sys_clk);
      check("abort_ack_low", 32'(bus.wb_ack_o), 32'd0);
    end
    idle_bus();
    @(negedge sys_clk);
    check("burst_ack_count", 32'(exp_q.size()), 32'd0);
  endtask
`endif

  vec_t vecs [13];
  vec_t v;

  initial begin
    vecs[0]  = '{1'b1, 32'h04, 32'hDEAD_BEEF, 4'hF, 3'b000, CtrlRst};
    vecs[1]  = '{1'b0, 32'h04, 32'h0,         4'hF, 3'b000, 32'hDEAD_BEEF};
    vecs[2]  = '{1'b1, 32'h08, 32'hFFFF_FFFF, 4'h5, 3'b000, 32'h0};
    vecs[3]  = '{1'b0, 32'h08, 32'h0,         4'hF, 3'b000, 32'h00FF_00FF};
    vecs[4]  = '{1'b1, 32'h00, 32'h1234_5678, 4'hF, 3'b000, RegId};
    vecs[5]  = '{1'b0, 32'h00, 32'h0,         4'hF, 3'b000, RegId};
    vecs[6]  = '{1'b1, 32'h3C, 32'h0BAD_F00D, 4'hA, 3'b000, 32'h0};
    vecs[7]  = '{1'b0, 32'h7C, 32'h0,         4'hF, 3'b000, 32'h0B00_F000};
    vecs[8]  = '{1'b1, 32'h08, 32'h1122_3344, 4'hA, 3'b000, 32'h00FF_00FF};
    vecs[9]  = '{1'b0, 32'h0B, 32'h0,         4'hF, 3'b000, 32'h11FF_33FF};
    vecs[10] = '{1'b0, 32'h04, 32'h0,         4'hF, 3'b010, 32'hDEAD_BEEF};
    vecs[11] = '{1'b1, 32'h10, 32'hFFFF_FFFF, 4'h0, 3'b000, 32'h0};
    vecs[12] = '{1'b0, 32'h10, 32'h0,         4'hF, 3'b000, 32'h0};

    idle_bus();
    mdl_reset();
    repeat (2) @(negedge sys_clk);
    check("rst_ack", 32'(bus.wb_ack_o), 32'd0);
    check("rst_dat", bus.wb_dat_o, 32'd0);
    check("rst_ctrl", ctrl_o, CtrlRst);
    sys_rst = 1'b0;

    for (int i = 0; i < 13; i++) begin
      classic(vecs[i]);
      if (i == 0) check("ctrl_after_write", ctrl_o, 32'hDEAD_BEEF);
    end
    check("ctrl_final", ctrl_o, 32'hDEAD_BEEF);

`ifdef WB_REGBANK_BURST_EN
    burst(1'b0, 32'h38, 4, 32'h0, -1, 1'b0);
    burst(1'b1, 32'h14, 4, 32'hA000_0005, 2, 1'b0);
    for (int w = 5; w < 9; w++) begin
      v = '{1'b0, 32'(w * 4), 32'h0, 4'hF, 3'b000, mdl_rd(4'(w))};
      classic(v);
    end
    burst(1'b1, 32'h28, 2, 32'hC000_000A, -1, 1'b1);
    v = '{1'b0, 32'h30, 32'h0, 4'hF, 3'b000, mdl_rd(4'd12)};
    classic(v);
    // Reset arrives while a burst write beat is being presented.
    @(negedge sys_clk);
    bus.wb_cyc_i = 1'b1;
    bus.wb_stb_i = 1'b1;
    bus.wb_we_i  = 1'b1;
    bus.wb_adr_i = 32'h08;
    bus.wb_dat_i = 32'h5555_5555;
    bus.wb_sel_i = 4'hF;
    bus.wb_cti_i = 3'b010;
    exp_q.push_back(mdl_rd(4'd2));
    @(negedge sys_clk);
    bus.wb_dat_i = 32'h6666_6666;
`else
    @(negedge sys_clk);
    bus.wb_cyc_i = 1'b1;
    bus.wb_stb_i = 1'b1;
    bus.wb_we_i  = 1'b1;
    bus.wb_adr_i = 32'h0C;
    bus.wb_dat_i = 32'h6666_6666;
    bus.wb_sel_i = 4'hF;
`endif
    sys_rst = 1'b1;
    mdl_reset();
    repeat (2) @(negedge sys_clk);
    check("midrst_ack", 32'(bus.wb_ack_o), 32'd0);
    check("midrst_dat", bus.wb_dat_o, 32'd0);
    check("midrst_ctrl", ctrl_o, CtrlRst);
    idle_bus();
    sys_rst = 1'b0;
    for (int w = 0; w < 16; w++) begin
      v = '{1'b0, 32'(w * 4), 32'h0, 4'hF, 3'b000, mdl_rd(4'(w))};
      classic(v);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
